arrhythmia_result_fifo: RTL

Downstream consumer of the arrhythmia classifier top level. Detects each completed inference on `done_flag`, captures the 2-element sigmoid output vector `y`, and decides the winning class with its margin. Queues the decision in a small FIFO, which a host or UART bridge drains over a valid/ready handshake. Inference results are therefore never lost to host back-pressure unless the FIFO overflows.

---
 rtl/arrhythmia_pkg.sv | 43 ++++
 rtl/result_fifo.sv | 62 ++++++
 rtl/arrhythmia_result_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/arrhythmia_pkg.sv
// Shared types and helpers for the arrhythmia classifier result path.
// Elements are sign-magnitude; arithmetic is done in BITSIZE+1-bit two's complement.
package arrhythmia_pkg;

  localparam int BITSIZE = 20;
  localparam int MAG_W   = BITSIZE - 1;
  localparam int TC_W    = BITSIZE + 1;

  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  localparam int CLASS_W    = 1;
  localparam int PROB_W     = BITSIZE;
  localparam int MARGIN_W   = BITSIZE;
  localparam int LOW_CONF_W = 1;

  typedef struct packed {
    logic [CLASS_W-1:0]    cls;
    logic [PROB_W-1:0]     prob;
    logic [MARGIN_W-1:0]   margin;
    logic [LOW_CONF_W-1:0] low_conf;
  } res_t;

  localparam int RES_W = $bits(res_t);

  // -0 maps to 0, so it compares equal to +0.
  function automatic logic signed [TC_W-1:0] sm_to_tc(input logic [BITSIZE-1:0] sm);
    logic signed [TC_W-1:0] mag;
    mag = signed'({2'b00, sm[MAG_W-1:0]});
    return sm[BITSIZE-1] ? -mag : mag;
  endfunction

  function automatic logic [BITSIZE-1:0] tc_to_sm(input logic signed [TC_W-1:0] tc);
    logic [TC_W-1:0] u;
    logic [TC_W-1:0] mag;
    u   = tc;
    mag = u[TC_W-1] ? (~u + TC_W'(1)) : u;
    if (mag > {2'b00, MAG_MAX}) begin
      return {u[TC_W-1], MAG_MAX};
    end
    return {u[TC_W-1], mag[MAG_W-1:0]};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic show-ahead synchronous FIFO; rd_dat is the head entry, zero read latency.
// Latency: write visible on the next cycle; a write to a full FIFO is accepted only with a same-cycle pop.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign rd_vld = ~empty;
  assign rd_dat = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so push-on-full is allowed alongside it.
  assign rd_en = rd_vld & rd_rdy;
  assign wr_en = wr_vld & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arrhythmia_result_fifo.sv
// Captures each classifier completion, picks the winning class and margin, and queues it for a host.
// Latency: 3 edges from done rising to res_valid; stages never stall, a full FIFO drops and counts.
module arrhythmia_result_fifo #(
  parameter int                   BITSIZE   = arrhythmia_pkg::BITSIZE,
  parameter int                   DEPTH     = 4,
  parameter logic [BITSIZE-1:0]   MARGIN_TH = 20'h00100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*BITSIZE-1:0]       y_in,
  input  logic                       done_flag_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_class,
  output logic [BITSIZE-1:0]         res_prob,
  output logic [BITSIZE-1:0]         res_margin,
  output logic                       res_low_conf,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 drop_count
);

  import arrhythmia_pkg::*;

  logic                       done_d;
  logic                       capture;
  logic                       s1_valid;
  logic [2*BITSIZE-1:0]       s1_y;
  logic                       s2_valid;
  res_t                       s2_rec;

  logic signed [BITSIZE:0]    p0;
  logic signed [BITSIZE:0]    p1;
  logic signed [BITSIZE:0]    diff;
  logic [BITSIZE-1:0]         diff_sm;
  res_t                       dec;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [RES_W-1:0]           fifo_dat;
  res_t                       head;
  logic                       pop;
  logic                       drop;

  assign capture = done_flag_in & ~done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_d   <= 1'b0;
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s2_valid <= 1'b0;
      s2_rec   <= '0;
    end else begin
      done_d   <= done_flag_in;
      s1_valid <= capture;
      if (capture) begin
        s1_y <= y_in;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rec <= dec;
      end
    end
  end

  // p1 - p0 spans at most +/-(2^BITSIZE - 2), so BITSIZE+1 bits cannot overflow.
  always_comb begin
    p0      = sm_to_tc(s1_y[BITSIZE-1:0]);
    p1      = sm_to_tc(s1_y[2*BITSIZE-1:BITSIZE]);
    diff    = p1 - p0;
    diff_sm = tc_to_sm(diff);
    dec          = '0;
    dec.cls      = (p1 > p0);
    dec.prob     = dec.cls[0] ? s1_y[2*BITSIZE-1:BITSIZE] : s1_y[BITSIZE-1:0];
    dec.margin   = diff_sm & {1'b0, {(BITSIZE-1){1'b1}}};
    dec.low_conf = (dec.margin < {1'b0, MARGIN_TH[BITSIZE-2:0]});
  end

  result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (s2_valid),
    .wr_dat (s2_rec),
    .rd_vld (res_valid),
    .rd_rdy (res_ready),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign pop  = res_valid & res_ready;
  assign drop = s2_valid & fifo_full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Head fields read as zero while empty so the reset state is clean.
  assign head         = res_t'(fifo_dat);
  assign res_class    = fifo_empty ? 1'b0 : head.cls[0];
  assign res_prob     = fifo_empty ? '0   : head.prob;
  assign res_margin   = fifo_empty ? '0   : head.margin;
  assign res_low_conf = fifo_empty ? 1'b0 : head.low_conf[0];

endmodule
